// File: rtl/sd_init.sv
// sd_init -- SPI-mode SD card initialisation engine.
//
// After reset it sends the power-up dummy clocks, then runs
// CMD0 -> CMD8 -> (CMD55/ACMD41)* -> CMD58 and raises init_o. It drives
// SD_CSn/SD_MOSI until init_o is high. After that, the top level hands the
// lines to the read engine.
//
// Build option: define SD_INIT_CMD58_EN to run the CMD58 step and report the
// OCR CCS bit on sdhc_o. Without it, a successful ACMD41 finishes the
// sequence and sdhc_o is tied to 0.
//
// Ports:
//   SD_CK     in   single clock, also the card clock
//   rst_n     in   synchronous active-low reset (applies to both edges)
//   SD_MISO   in   card data out, sampled on the rising edge
//   SD_MOSI   out  card data in, registered on the falling edge
//   SD_CSn    out  card chip select, registered on the falling edge
//   init_req  in   restart pulse, honoured only in DONE / ERR
//   init_o    out  card initialised (level)
//   init_err  out  initialisation failed (level)
//   sdhc_o    out  card reported CCS=1
module sd_init #(
   parameter int DUMMY_CLKS     = 80,
   parameter int RESP_TIMEOUT   = 128,
   parameter int ACMD41_RETRIES = 1000,
   parameter int GAP_CLKS       = 8
) (
   input  logic SD_CK,
   input  logic rst_n,
   input  logic SD_MISO,
   output logic SD_MOSI,
   output logic SD_CSn,
   input  logic init_req,
   output logic init_o,
   output logic init_err,
   output logic sdhc_o
);
   localparam int CW = 16;

   typedef enum logic [2:0] {IDLE, DUMMY, TX, RX, GAP, DONE, ERR} state_t;
   typedef enum logic [2:0] {S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58} step_t;

   state_t        state, state_n;
   step_t         step, step_n;
   logic [CW-1:0] cnt, cnt_n, retry, retry_n;
   logic          hunt, hunt_n, v2, v2_n;
   logic [38:0]   rx, rx_n;
   logic [39:0]   rx_full;
   logic [47:0]   frame;
   logic [7:0]    r1;
   logic          long_rsp, cs_nxt, mosi_nxt;
`ifdef SD_INIT_CMD58_EN
   logic          sdhc, sdhc_n;
`endif

   // R7 (CMD8) and R3 (CMD58) carry 32 bits after R1.
`ifdef SD_INIT_CMD58_EN
   assign long_rsp = (step == S_CMD8) || (step == S_CMD58);
`else
   assign long_rsp = (step == S_CMD8);
`endif

   always_comb begin
      case (step)
         S_CMD0:   frame = 48'h40_0000_0000_95;
         S_CMD8:   frame = 48'h48_0000_01AA_87;
         S_CMD55:  frame = 48'h77_0000_0000_65;
         S_ACMD41: frame = {8'h69, (v2 ? 8'h40 : 8'h00), 24'h0, 8'h77};
         S_CMD58:  frame = 48'h7A_0000_0000_FD;
         default:  frame = '1;
      endcase
   end

   always_comb begin
      state_n  = state;
      step_n   = step;
      cnt_n    = cnt;
      retry_n  = retry;
      hunt_n   = hunt;
      v2_n     = v2;
      rx_n     = rx;
`ifdef SD_INIT_CMD58_EN
      sdhc_n   = sdhc;
`endif
      rx_full  = {rx, SD_MISO};
      r1       = long_rsp ? rx_full[39:32] : rx_full[7:0];
      cs_nxt   = 1'b1;
      mosi_nxt = 1'b1;
      case (state)
         IDLE: begin
            state_n = DUMMY;
            cnt_n   = '0;
         end
         DUMMY: begin
            if (cnt == CW'(DUMMY_CLKS - 1)) begin
               state_n = TX;
               cnt_n   = '0;
               step_n  = S_CMD0;
            end else cnt_n = cnt + 1'b1;
         end
         TX: begin
            cs_nxt   = 1'b0;
            mosi_nxt = frame[6'd47 - cnt[5:0]];
            if (cnt == CW'(47)) begin
               state_n = RX;
               cnt_n   = '0;
               hunt_n  = 1'b1;
            end else cnt_n = cnt + 1'b1;
         end
         RX: begin
            cs_nxt = 1'b0;
            if (hunt) begin
               // cnt is the number of idle bits seen so far. A start bit on
               // the RESP_TIMEOUT-th cycle is still accepted.
               if (cnt == CW'(RESP_TIMEOUT)) state_n = ERR;
               else if (!SD_MISO) begin
                  hunt_n = 1'b0;
                  cnt_n  = CW'(1);
                  rx_n   = rx_full[38:0];
               end else cnt_n = cnt + 1'b1;
            end else begin
               rx_n = rx_full[38:0];
               if (cnt != (long_rsp ? CW'(39) : CW'(7))) cnt_n = cnt + 1'b1;
               else begin
                  // Last response bit: judge the full response now.
                  state_n = GAP;
                  cnt_n   = '0;
                  case (step)
                     S_CMD0: begin
                        if (r1 == 8'h01) step_n = S_CMD8;
                        else state_n = ERR;
                     end
                     S_CMD8: begin
                        if (r1 == 8'h01 && rx_full[11:0] == 12'h1AA) v2_n = 1'b1;
                        else if (r1 != 8'h01 && r1[2]) v2_n = 1'b0;  // illegal cmd: v1 card
                        else state_n = ERR;
                        step_n  = S_CMD55;
                        retry_n = CW'(ACMD41_RETRIES);
                     end
                     S_CMD55: begin
                        if (r1 == 8'h00 || r1 == 8'h01) step_n = S_ACMD41;
                        else state_n = ERR;
                     end
                     S_ACMD41: begin
                        if (r1 == 8'h00) begin
`ifdef SD_INIT_CMD58_EN
                           step_n = S_CMD58;
`else
                           state_n = DONE;
`endif
                        end else if (r1 == 8'h01) begin
                           retry_n = retry - 1'b1;
                           if (retry == CW'(1)) state_n = ERR;
                           else step_n = S_CMD55;
                        end else state_n = ERR;
                     end
`ifdef SD_INIT_CMD58_EN
                     S_CMD58: begin
                        if (r1 == 8'h00) begin
                           sdhc_n  = v2 & rx_full[30];
                           state_n = DONE;
                        end else state_n = ERR;
                     end
`endif
                     default: state_n = ERR;
                  endcase
               end
            end
         end
         GAP: begin
            if (cnt == CW'(GAP_CLKS - 1)) begin
               state_n = TX;
               cnt_n   = '0;
            end else cnt_n = cnt + 1'b1;
         end
         DONE, ERR: begin
            if (init_req) begin
               state_n = DUMMY;
               cnt_n   = '0;
`ifdef SD_INIT_CMD58_EN
               sdhc_n  = 1'b0;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge SD_CK) begin
      if (!rst_n) begin
         state <= IDLE;
         step  <= S_CMD0;
         cnt   <= '0;
         retry <= '0;
         hunt  <= 1'b0;
         v2    <= 1'b0;
         rx    <= '0;
`ifdef SD_INIT_CMD58_EN
         sdhc  <= 1'b0;
`endif
      end else begin
         state <= state_n;
         step  <= step_n;
         cnt   <= cnt_n;
         retry <= retry_n;
         hunt  <= hunt_n;
         v2    <= v2_n;
         rx    <= rx_n;
`ifdef SD_INIT_CMD58_EN
         sdhc  <= sdhc_n;
`endif
      end
   end

   // Card lines change on the falling edge so they are stable for the
   // card's rising-edge sample.
   always_ff @(negedge SD_CK) begin
      if (!rst_n) begin
         SD_CSn  <= 1'b1;
         SD_MOSI <= 1'b1;
      end else begin
         SD_CSn  <= cs_nxt;
         SD_MOSI <= mosi_nxt;
      end
   end

   assign init_o   = (state == DONE);
   assign init_err = (state == ERR);
`ifdef SD_INIT_CMD58_EN
   assign sdhc_o   = sdhc;
`else
   assign sdhc_o   = 1'b0;
`endif

endmodule

// File: tb/tb_sd_init.sv
// tb_sd_init -- bench for sd_init. It uses a behavioural SPI card model.
// Each run pushes its expected outcome into a queue. A monitor pops the queue
// whenever init_o or init_err rises and compares the outcome.
module tb_sd_init;
   localparam int RESP_TIMEOUT = 128;
   localparam int GAP_CLKS     = 8;
   localparam int DUMMY_CLKS   = 80;
`ifdef SD_INIT_CMD58_EN
   localparam int HAS58 = 1;
`else
   localparam int HAS58 = 0;
`endif

   logic SD_CK = 1'b0, rst_n = 1'b0, SD_MISO = 1'b1, init_req = 1'b0;
   logic SD_MOSI, SD_CSn, init_o, init_err, sdhc_o;

   sd_init #(.DUMMY_CLKS(DUMMY_CLKS), .RESP_TIMEOUT(RESP_TIMEOUT),
             .ACMD41_RETRIES(4), .GAP_CLKS(GAP_CLKS)) dut (
      .SD_CK(SD_CK), .rst_n(rst_n), .SD_MISO(SD_MISO), .SD_MOSI(SD_MOSI),
      .SD_CSn(SD_CSn), .init_req(init_req), .init_o(init_o),
      .init_err(init_err), .sdhc_o(sdhc_o));

   always #5 SD_CK = ~SD_CK;

   int n_pass = 0, n_chk = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- card model ----------------
   logic        cfg_silent;
   logic [7:0]  cfg_r8;
   logic [31:0] cfg_echo;
   int          cfg_busy;     // ACMD41 answers 0x01 this many times, then 0x00
   int          cfg_lat;      // response start bit N cycles after last cmd bit
   logic [7:0]  cfg_hh;       // ACMD41 argument byte the DUT must send
   logic [31:0] cfg_ocr = 32'hC0FF8000;
   int          n41 = 0, n55 = 0, n58 = 0, bcnt = 0, hi_run = 0;
   int          cyc = 0, last_cmd_cyc = 0;
   logic [7:0]  last_cmd = 8'h00;
   logic        prev_frame = 1'b0;
   logic [47:0] sh = '0;
   bit          resp_q[$];

   task automatic push_resp(input logic [39:0] bits, input int len);
      for (int i = 1; i < cfg_lat; i++) resp_q.push_back(1'b1);
      for (int i = len - 1; i >= 0; i--) resp_q.push_back(bits[i]);
   endtask

   task automatic decode();
      last_cmd     = sh[47:40];
      last_cmd_cyc = cyc;
      prev_frame   = 1'b1;
      case (sh[47:40])
         8'h40: begin
            chk("cmd0_frame", 64'(sh), 64'h400000000095);
            if (!cfg_silent) push_resp({32'h0, 8'h01}, 8);
         end
         8'h48: begin
            chk("cmd8_frame", 64'(sh), 64'h48000001AA87);
            push_resp({cfg_r8, cfg_echo}, 40);
         end
         8'h77: begin
            n55++;
            chk("cmd55_frame", 64'(sh), 64'h770000000065);
            push_resp({32'h0, 8'h01}, 8);
         end
         8'h69: begin
            n41++;
            chk("acmd41_frame", 64'(sh), 64'({8'h69, cfg_hh, 24'h0, 8'h77}));
            push_resp({32'h0, ((n41 <= cfg_busy) ? 8'h01 : 8'h00)}, 8);
         end
         8'h7A: begin
            n58++;
            chk("cmd58_frame", 64'(sh), 64'h7A00000000FD);
            push_resp({8'h00, cfg_ocr}, 40);
         end
         default: begin
            n_chk++;
            $display("FAIL unknown_cmd: got frame %h expected a known command", sh);
         end
      endcase
   endtask

   always @(posedge SD_CK) begin
      cyc++;
      if (SD_CSn) begin
         bcnt = 0;
         hi_run++;
      end else begin
         if (hi_run != 0 && prev_frame) chk("gap_cs_high", 64'(hi_run), 64'(GAP_CLKS));
         hi_run = 0;
         if (bcnt < 48) begin
            sh = {sh[46:0], SD_MOSI};
            bcnt++;
            if (bcnt == 48) decode();
         end
      end
   end

   always @(negedge SD_CK) begin
      if (resp_q.size() != 0) SD_MISO = resp_q.pop_front();
      else SD_MISO = 1'b1;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic o, err, sdhc;
      int   n41, n55, n58, lat;
   } exp_t;
   exp_t exp_q[$];
   int   done_cnt = 0;
   logic fin_prev = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(negedge SD_CK);
         if ((init_o | init_err) && !fin_prev) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_completion: init_o=%b init_err=%b", init_o, init_err);
            end else begin
               e = exp_q.pop_front();
               chk("init_o",   64'(init_o),   64'(e.o));
               chk("init_err", 64'(init_err), 64'(e.err));
               chk("sdhc_o",   64'(sdhc_o),   64'(e.sdhc));
               chk("acmd41_count", 64'(n41), 64'(e.n41));
               chk("cmd55_count",  64'(n55), 64'(e.n55));
               chk("cmd58_count",  64'(n58), 64'(e.n58));
               if (e.lat >= 0) chk("resp_timeout_cycles", 64'(cyc - last_cmd_cyc), 64'(e.lat));
            end
            prev_frame = 1'b0;
            done_cnt++;
            @(posedge SD_CK);
            chk("lines_idle_after_end", 64'({SD_CSn, SD_MOSI}), 64'b11);
         end
         fin_prev = init_o | init_err;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cfg_card(input logic silent, input logic [7:0] r8, input logic [31:0] echo,
                           input int busy, input int lat, input logic [7:0] hh);
      cfg_silent = silent; cfg_r8 = r8; cfg_echo = echo;
      cfg_busy = busy; cfg_lat = lat; cfg_hh = hh;
      n41 = 0; n55 = 0; n58 = 0; last_cmd = 8'h00;
   endtask

   task automatic push_exp(input logic o, input logic err, input logic sdhc,
                           input int e41, input int e55, input int e58, input int lat);
      exp_t e;
      e.o = o; e.err = err; e.sdhc = sdhc;
      e.n41 = e41; e.n55 = e55; e.n58 = e58; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input string name, input int limit);
      int start;
      start = done_cnt;
      for (int i = 0; i < limit; i++) begin
         @(posedge SD_CK);
         if (done_cnt != start) return;
      end
      n_chk++;
      $display("FAIL %s: no completion within %0d cycles", name, limit);
   endtask

   // n_high cycles of CS/MOSI high, then CS low on the next cycle.
   task automatic dummy_check(input string name, input int n_high);
      int bad;
      bad = 0;
      for (int i = 0; i < n_high; i++) begin
         @(posedge SD_CK);
         if (!(SD_CSn && SD_MOSI)) bad++;
      end
      chk({name, "_dummy_high"}, 64'(bad), 64'd0);
      @(posedge SD_CK);
      chk({name, "_cs_falls"}, 64'(SD_CSn), 64'd0);
   endtask

   task automatic restart(input string name);
      @(negedge SD_CK); init_req = 1'b1;
      @(negedge SD_CK); init_req = 1'b0;
      chk({name, "_flags_clear"}, 64'({init_o, init_err, sdhc_o}), 64'd0);
      dummy_check(name, DUMMY_CLKS);
   endtask

   task automatic do_reset();
      @(negedge SD_CK); rst_n = 1'b0;
      repeat (3) @(negedge SD_CK);
      chk("reset_values", 64'({SD_CSn, SD_MOSI, init_o, init_err, sdhc_o}), 64'b11000);
      resp_q.delete(); prev_frame = 1'b0; hi_run = 0;
      rst_n = 1'b1;
   endtask

   initial begin
      bit hit;
      // v2 card: two busy ACMD41 replies, then ready
      cfg_card(1'b0, 8'h01, 32'h000001AA, 2, 1, 8'h40);
      push_exp(1'b1, 1'b0, HAS58[0], 3, 3, HAS58, -1);
      do_reset();
      dummy_check("reset", DUMMY_CLKS + 1);   // includes the IDLE cycle
      wait_done("v2_card", 5000);

      // v1 card with the latest acceptable response (N = RESP_TIMEOUT)
      cfg_card(1'b0, 8'h05, 32'hFFFFFFFF, 0, RESP_TIMEOUT, 8'h00);
      push_exp(1'b1, 1'b0, 1'b0, 1, 1, HAS58, -1);
      restart("v1");
      wait_done("v1_card", 5000);

      // silent card: error RESP_TIMEOUT+1 cycles after the last CMD0 bit
      cfg_card(1'b1, 8'h01, 32'h000001AA, 0, 1, 8'h40);
      push_exp(1'b0, 1'b1, 1'b0, 0, 0, 0, RESP_TIMEOUT + 1);
      restart("timeout");
      wait_done("timeout", 2000);

      // ACMD41 never ready: 4 pairs, then error
      cfg_card(1'b0, 8'h01, 32'h000001AA, 1000, 3, 8'h40);
      push_exp(1'b0, 1'b1, 1'b0, 4, 4, 0, -1);
      restart("exhaust");
      wait_done("exhaust", 5000);

      // bad CMD8 echo
      cfg_card(1'b0, 8'h01, 32'h000001AB, 0, 2, 8'h40);
      push_exp(1'b0, 1'b1, 1'b0, 0, 0, 0, -1);
      restart("bad_echo");
      wait_done("bad_echo", 3000);

      // reset in the middle of CMD8, then a full v2 run
      cfg_card(1'b0, 8'h01, 32'h000001AA, 2, 2, 8'h40);
      restart("pre_reset");
      hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(posedge SD_CK); #1;
         if (last_cmd == 8'h40 && bcnt == 20 && !SD_CSn) hit = 1'b1;
      end
      if (!hit) begin
         n_chk++;
         $display("FAIL mid_cmd8_reached: got no CMD8 bit 20 expected one within 2000 cycles");
      end
      rst_n = 1'b0;
      @(negedge SD_CK);
      @(posedge SD_CK);
      chk("mid_reset_lines", 64'({SD_CSn, SD_MOSI}), 64'b11);
      repeat (2) @(negedge SD_CK);
      resp_q.delete(); prev_frame = 1'b0; hi_run = 0;
      cfg_card(1'b0, 8'h01, 32'h000001AA, 2, 2, 8'h40);
      push_exp(1'b1, 1'b0, HAS58[0], 3, 3, HAS58, -1);
      rst_n = 1'b1;
      dummy_check("mid_reset", DUMMY_CLKS + 1);
      wait_done("after_reset", 5000);

      repeat (4) @(negedge SD_CK);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of run expected finish before 500000 time units");
      $fatal(1, "watchdog");
   end

endmodule
